// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: NOP encoding, occupancy width and the
// stage-control priority used by both the hazard unit and pipeline registers.
package mips_pkg;

  // sll $0,$0,0 -- the canonical MIPS NOP, driven by empty IF/ID stages
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    CTRL_RESET   = 2'd0,
    CTRL_STALL   = 2'd1,
    CTRL_BUBBLE  = 2'd2,
    CTRL_ADVANCE = 2'd3
  } stage_ctrl_e;

  // Reset beats stall, stall beats bubble, and only then does data move.
  function automatic stage_ctrl_e resolveCtrl(input logic rst, input logic stall,
                                              input logic bubble);
    if (rst)
      return CTRL_RESET;
    else if (stall)
      return CTRL_STALL;
    else if (bubble)
      return CTRL_BUBBLE;
    else
      return CTRL_ADVANCE;
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One valid+data holding register for a pipeline stage. Hold beats load,
// load beats clear; the data output reads EMPTY_VAL whenever the entry is empty.
module pipe_stage_entry #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] EMPTY_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!hold_i) begin
      if (load_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else if (clear_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= EMPTY_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = valid_q ? data_q : EMPTY_VAL;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/bubble control and ready/valid handshake.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
  import mips_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] EMPTY_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occupancy
);

  stage_ctrl_e       stageCtrl;
  logic              holdAll;
  logic              flush;
  logic              inFire;
  logic              outFire;
  logic              mainValid;
  logic              mainLoad;
  logic              mainClear;
  logic [DATA_W-1:0] mainLoadData;
  logic [DATA_W-1:0] mainData;

  assign stageCtrl = resolveCtrl(rst, stall, bubble);
  assign holdAll   = (stageCtrl == CTRL_STALL);
  assign flush     = (stageCtrl == CTRL_BUBBLE);

  assign inFire  = in_valid & in_ready & ~stall;
  assign outFire = mainValid & out_ready & ~stall;

`ifdef PIPE_STAGE_SKID_EN
  logic              skidValid;
  logic              skidLoad;
  logic              skidClear;
  logic [DATA_W-1:0] skidData;

  // in_ready comes straight from the skid flop, so upstream never sees a
  // combinational path from out_ready. A full S implies inFire is 0.
  assign in_ready = ~skidValid;

  always_comb begin
    mainLoad     = 1'b0;
    mainLoadData = in_data;
    skidLoad     = 1'b0;
    if (!flush) begin
      if (outFire && skidValid) begin
        mainLoad     = 1'b1;
        mainLoadData = skidData;
      end else if (inFire && (!mainValid || outFire)) begin
        mainLoad = 1'b1;
      end else if (inFire) begin
        skidLoad = 1'b1;
      end
    end
  end

  assign mainClear = flush | outFire;
  assign skidClear = flush | (outFire & skidValid);

  pipe_stage_entry #(
    .DATA_W    (DATA_W),
    .EMPTY_VAL (EMPTY_VAL)
  ) uSkid (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (holdAll),
    .clear_i (skidClear),
    .load_i  (skidLoad),
    .data_i  (in_data),
    .valid_o (skidValid),
    .data_o  (skidData)
  );

  assign occupancy = OCC_W'(mainValid) + OCC_W'(skidValid);
`else
  // Combinational ready lets a full stage accept a new beat while it drains.
  assign in_ready     = ~stall & (~mainValid | out_ready);
  assign mainLoad     = inFire & ~flush;
  assign mainLoadData = in_data;
  assign mainClear    = flush | outFire;
  assign occupancy    = {1'b0, mainValid};
`endif

  pipe_stage_entry #(
    .DATA_W    (DATA_W),
    .EMPTY_VAL (EMPTY_VAL)
  ) uMain (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (holdAll),
    .clear_i (mainClear),
    .load_i  (mainLoad),
    .data_i  (mainLoadData),
    .valid_o (mainValid),
    .data_o  (mainData)
  );

  assign out_valid = mainValid;
  assign out_data  = mainData;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps followed by random
// traffic, all compared against a queue-based model of the stage.
module tb_pipe_stage_reg;
  import mips_pkg::*;

  localparam int          DATA_W = 32;
  localparam logic [31:0] EMPTY  = 32'hE0E0_E0E0;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk;
  logic              rst;
  logic              stall;
  logic              bubble;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [OCC_W-1:0]  occupancy;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [31:0] model[$];

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .EMPTY_VAL (EMPTY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .bubble    (bubble),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ready as seen by upstream: a one-entry stage can always take a beat if it
  // is empty or being drained; a two-entry stage only looks at its own fill.
  function automatic logic expReady();
`ifdef PIPE_STAGE_SKID_EN
    return model.size() < CAP;
`else
    return !stall && (model.size() < CAP || out_ready);
`endif
  endfunction

  task automatic checkOutput(input string tag);
    logic [31:0] expData;
    expData = (model.size() > 0) ? model[0] : EMPTY;
    checkVal({tag, " out_valid"}, 32'(out_valid), 32'(model.size() > 0));
    checkVal({tag, " out_data"}, out_data, expData);
    checkVal({tag, " occupancy"}, 32'(occupancy), 32'(model.size()));
    checkVal({tag, " in_ready"}, 32'(in_ready), 32'(expReady()));
  endtask

  task automatic updateModel();
    logic take;
    logic give;
    if (rst) begin
      model.delete();
    end else if (!stall) begin
      if (bubble) begin
        model.delete();
      end else begin
        take = in_valid && expReady();
        give = (model.size() > 0) && out_ready;
        if (give) void'(model.pop_front());
        if (take) model.push_back(in_data);
      end
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic st, input logic bu, input logic iv,
                               input logic [31:0] id, input logic ordy, input string tag);
    rst       = rs;
    stall     = st;
    bubble    = bu;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    stall     = 1'b0;
    bubble    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model.delete();
    #1;
    checkVal("reset out_valid", 32'(out_valid), 32'd0);
    checkVal("reset out_data", out_data, EMPTY);
    checkVal("reset occupancy", 32'(occupancy), 32'd0);
    checkVal("reset in_ready", 32'(in_ready), 32'd1);

    // back-to-back stream, one cycle behind the input
    applyStimulus(0, 0, 0, 1, 32'h1, 1, "stream1");
    checkVal("stream d1", out_data, 32'h1);
    checkVal("stream occ1", 32'(occupancy), 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h2, 1, "stream2");
    checkVal("stream d2", out_data, 32'h2);
    applyStimulus(0, 0, 0, 1, 32'h3, 1, "stream3");
    checkVal("stream d3", out_data, 32'h3);
    checkVal("stream occ3", 32'(occupancy), 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, "drain");
    checkVal("drain valid", 32'(out_valid), 32'd0);

    // stall freezes a held beat and refuses new input
    applyStimulus(0, 0, 0, 1, 32'hA, 0, "loadA");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, 32'hC, 1, "stall");
      checkVal("stall data", out_data, 32'hA);
      checkVal("stall occ", 32'(occupancy), 32'd1);
    end

    // bubble wins over a simultaneous offer
    applyStimulus(0, 0, 1, 1, 32'hB, 0, "bubble");
    checkVal("bubble valid", 32'(out_valid), 32'd0);
    checkVal("bubble data", out_data, EMPTY);
    checkVal("bubble occ", 32'(occupancy), 32'd0);

    // bubble under stall is ignored
    applyStimulus(0, 0, 0, 1, 32'h5, 0, "load5");
    applyStimulus(0, 1, 1, 0, 32'h0, 0, "bubstall");
    checkVal("bubstall valid", 32'(out_valid), 32'd1);
    checkVal("bubstall data", out_data, 32'h5);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, "drain2");

    // fill against a blocked consumer, then release it
    applyStimulus(0, 0, 0, 1, 32'h10, 0, "fill10");
    applyStimulus(0, 0, 0, 1, 32'h11, 0, "fill11");
    applyStimulus(0, 0, 0, 1, 32'h12, 0, "fill12");
`ifdef PIPE_STAGE_SKID_EN
    checkVal("skid head", out_data, 32'h10);
    checkVal("skid occ", 32'(occupancy), 32'd2);
    checkVal("skid ready", 32'(in_ready), 32'd0);
`endif
    applyStimulus(0, 0, 0, 1, 32'h12, 1, "rel1");
`ifdef PIPE_STAGE_SKID_EN
    checkVal("skid order1", out_data, 32'h11);
`endif
    applyStimulus(0, 0, 0, 1, 32'h12, 1, "rel2");
`ifdef PIPE_STAGE_SKID_EN
    checkVal("skid order2", out_data, 32'h12);
`endif
    applyStimulus(0, 0, 0, 0, 32'h0, 1, "rel3");

    // reset drops everything even while stalled
    applyStimulus(0, 0, 0, 1, 32'h20, 0, "rfill1");
    applyStimulus(0, 0, 0, 1, 32'h21, 0, "rfill2");
    applyStimulus(1, 1, 0, 1, 32'h22, 0, "rstmid");
    rst   = 1'b0;
    stall = 1'b0;
    #1;
    checkVal("rstmid valid", 32'(out_valid), 32'd0);
    checkVal("rstmid occ", 32'(occupancy), 32'd0);
    checkVal("rstmid ready", 32'(in_ready), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      applyStimulus($urandom_range(0, 511) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 31) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom,
                    $urandom_range(0, 3) != 0,
                    "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: next-generation inter-stage register for the MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a `DATA_W`-bit payload with a valid bit, honours the hazard unit's `stall` and `bubble` controls, and adds a ready/valid handshake so stages can back-pressure each other. An optional two-entry skid buffer registers `in_ready` to break the combinational ready path between stages.

## Interface
- `DATA_W`, 32: payload width in bits, legal range 1..256.
- `EMPTY_VAL`, 0: value driven on `out_data` whenever `out_valid`=0. For IF/ID this is the NOP encoding.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `stall` input 1: hazard-unit freeze; no state changes while high.
- `bubble` input 1: hazard-unit flush; empties the stage.
- `in_valid` input 1: upstream beat present.
- `in_data` input `DATA_W`: upstream payload.
- `in_ready` output 1: stage can accept a beat.
- `out_valid` output 1: stage holds a beat.
- `out_data` output `DATA_W`: payload of the oldest held beat, else `EMPTY_VAL`.
- `out_ready` input 1: downstream accepts the beat.
- `occupancy` output 2: number of beats held (0..1, or 0..2 with skid).

## Operation
- Accept: `in_fire = in_valid & in_ready & ~stall`. Emit: `out_fire = out_valid & out_ready & ~stall`. Upstream and downstream stages receive the same `stall`, so neither side counts a transfer while it is high.
- Priority on each edge: `rst` > `stall` > `bubble` > normal transfer.
- `stall`=1 freezes all state, including any `bubble` request in the same cycle. `bubble` has no effect while `stall` is high.
- `bubble`=1 with `stall`=0 empties every entry. Any beat offered that cycle is discarded, even if `in_ready`=1; upstream must treat it as flushed.
- Normal operation, single-entry (macro off): main entry M. `in_ready = ~stall & (~M.valid | out_ready)`, which is combinational. On `in_fire`, M loads `in_data`. On `out_fire` without `in_fire`, M empties. When both fire in the same cycle, M takes the new beat with no gap.
- Normal operation, skid mode (macro on): entries M (drives outputs) and S. `in_ready = ~S.valid`, which is registered.
  - `in_fire` with M empty, or with `out_fire`: load into M.
  - `in_fire` with M full and no `out_fire`: load into S.
  - `out_fire` with S full: M takes S and S empties.
  - Beats always leave in order. S is never valid while M is empty.
- `out_data` equals `EMPTY_VAL` exactly when `out_valid`=0. Payload is never truncated or extended.
- `occupancy` = M.valid + S.valid.

## Timing
- Reset values: `out_valid`=0, `out_data`=`EMPTY_VAL`, `occupancy`=0. `in_ready`=1 in skid mode; in single-entry mode `in_ready` follows `~stall`.
- Latency: a beat accepted at edge N appears on `out_*` after edge N, one cycle later. In skid mode a beat parked in S reaches M one edge after the next `out_fire`.
- Throughput: one beat per cycle with `out_ready` held at 1, in both modes.
- Skid mode: `in_ready` deasserts the cycle after S fills. It reasserts the cycle after S drains, or after a `bubble` or `rst`.
- `rst` asserted mid-stream drops all held beats on that edge, including during `stall`.
- `bubble` clears the stage on the same edge. `out_valid`=0 in the following cycle.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid buffer, registered `in_ready`, `occupancy` 0..2.
- `PIPE_STAGE_SKID_EN` undefined: single entry, combinational `in_ready`, `occupancy` 0..1 (bit 1 tied 0).
- Handshake semantics and the stall/bubble priority are identical in both modes.

## Structure
- The shared package `mips_pkg` holds:
  - the NOP encoding constant used as `EMPTY_VAL` for IF/ID,
  - the occupancy width constant (2),
  - the stage-control priority definitions shared with the hazard unit.
- Sub-module `pipe_stage_entry`: one valid+data register with `load`, `clear` and `hold` controls, and output forced to `EMPTY_VAL` when invalid. It is instantiated once for M, plus once for S under the macro.

## Test plan
- Reset, then stream 0x1, 0x2, 0x3 with `out_ready`=1 -> outputs 0x1, 0x2, 0x3 on consecutive cycles, one cycle behind input; `occupancy` stays 1.
- `stall`=1 for 3 cycles while holding 0xA with `in_valid`=1 -> `out_data` stays 0xA, `occupancy` unchanged, no input accepted.
- `bubble` and `in_valid`=1 with 0xB both asserted in one cycle -> next cycle `out_valid`=0, `out_data`=`EMPTY_VAL`, 0xB lost. `bubble` with `stall` -> no change.
- Skid mode, `out_ready`=0, offer 0x10, 0x11, 0x12 -> 0x10 in M, 0x11 in S, `in_ready`=0, `occupancy`=2. Then `out_ready`=1 -> 0x10, 0x11, 0x12 emitted in order.
- `rst` asserted with `occupancy`=2 -> next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1.
- Random valid/ready/stall/bubble for 10k cycles against a scoreboard model -> no loss, duplication or reordering except the beats a `bubble` discards.
